irq_source_arbiter: RTL and testbench
=====================================

Name: irq_source_arbiter

Overview:
- Collects single-cycle event pulses from up to N DMA/application sources into per-source pending bits.
- Selects one eligible source round-robin and presents it as int_valid/int_vector to the downstream interrupt controller.
- Holds the request until that controller returns its one-cycle int_done pulse.
- Enforces a programmable minimum gap between consecutive interrupts so the PCIe core is not flooded.

Parameters:
- N_SRC, 8, number of interrupt sources (1..32).
- VECTOR_BASE, 8'h00, vector value of source 0; source i drives VECTOR_BASE+i (mod 256).
- HOLDOFF_W, 16, width of the holdoff counter and of i_holdoff.
- CNT_W, 16, width of the coalesce counter.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset.
- src_irq  in  N_SRC  per-source event pulses; each set bit is one event.
- src_mask  in  N_SRC  1 = source masked (still latches, never granted).
- i_holdoff  in  HOLDOFF_W  minimum idle cycles after int_done before the next issue; sampled at entry to HOLDOFF.
- int_valid  out  1  request to the interrupt controller.
- int_vector  out  8  vector of the granted source; stable while int_valid=1.
- int_done  in  1  one-cycle completion pulse from the interrupt controller.
- pending  out  N_SRC  current pending bits.
- coalesced_cnt  out  CNT_W  saturating count of events that hit an already-pending source.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (synchronous, active-high on i_rst, clock i_clk) clears:
  - int_valid=0, int_vector=0, pending=0, coalesced_cnt=0, busy=0.
  - Round-robin pointer = 0 (source 0 has highest priority first); state = IDLE.
  - Any in-flight request is dropped.
- Pending update, every cycle:
  - pending_next = (pending & ~grant_clr) | src_irq.
  - Set wins over clear in the same cycle.
- Coalesce:
  - For each i with src_irq[i]=1 and pending[i]=1 (pre-update value), add 1 to coalesced_cnt.
  - Multiple hits in one cycle add their popcount.
  - Saturates at all-ones; never wraps.
- Eligible = pending & ~src_mask.
- States IDLE, ISSUE, HOLDOFF:
  - IDLE: if eligible != 0, the arbiter picks the first set bit at or after the pointer, cyclically. At the next edge:
    - int_valid<=1, int_vector<=VECTOR_BASE+idx.
    - pending[idx] cleared (grant_clr), pointer<=idx+1 mod N_SRC, state->ISSUE.
    - Latency: an event arriving in IDLE with holdoff expired gives int_valid=1 two edges after the src_irq pulse (one edge to latch pending, one to issue).
  - ISSUE:
    - int_valid and int_vector held constant.
    - When int_done is sampled 1: int_valid<=0 at that edge, state->HOLDOFF, counter loaded with i_holdoff.
    - int_done while in IDLE/HOLDOFF is ignored.
  - HOLDOFF:
    - Counter decrements each cycle; at 0 return to IDLE.
    - i_holdoff=0 gives HOLDOFF→IDLE in one cycle.
    - Minimum spacing is int_done edge to next int_valid rise = i_holdoff+2 cycles.
- int_valid drops the same edge int_done is sampled. The downstream controller therefore never re-triggers on a stale request.
- Granted source re-pulsing while in ISSUE re-sets its pending bit. This is not coalesced, since the bit was cleared, and it is issued again later.
- Masking a source while it is in ISSUE does not abort the request. Unmasking a pending source makes it eligible the next IDLE cycle.
- All sources masked: stays IDLE; pending keeps accumulating.

Decomposition:
- Shared package irq_pkg holds:
  - State enum (IDLE, ISSUE, HOLDOFF).
  - Localparam IDX_W = clog2(N_SRC).
  - Vector width constant 8.
  - A saturating-add function for coalesced_cnt.
- One sub-module: irq_rr_arbiter, combinational round-robin pick.
  - Inputs: req vector, pointer.
  - Outputs: any, idx, one-hot grant.

Test Plan:
- Single source: src_irq=8'h04, holdoff=0, controller model returns int_done 3 cycles after int_valid rises → int_valid rises 2 edges after the pulse; int_vector=VECTOR_BASE+2; pending=0 after issue; int_valid=0 at the int_done edge.
- Round robin: src_irq=8'hFF for one cycle → vectors issued in order 0,1,…,7. Then pulse 8'h03 → order 0,1; after grant 7 the pointer=0.
- Coalesce: src_irq bit 5 pulsed 4 times while pending and masked → coalesced_cnt=3. Unmask → exactly one interrupt with vector 5. Saturation: force 65536 hits → cnt=16'hFFFF.
- Holdoff: i_holdoff=10, two sources pending → the second int_valid rises exactly 12 cycles after the first int_done edge.
- Simultaneous events: source 1 pulses in the grant cycle of source 1 → pending[1]=1 after grant, no coalesce increment, a second vector-1 interrupt follows.
- Reset mid-ISSUE: assert i_rst while int_valid=1 → next edge int_valid=0, pending=0, pointer=0. A late int_done after reset is ignored (state stays IDLE).

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt source arbiter slice.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    HOLDOFF = 2'd2
  } irq_state_e;

  localparam int VEC_W = 8;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Saturating add; callers pass their counter's all-ones value as max.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, max}) return max;
    return sum[31:0];
  endfunction

endpackage

// File: rtl/irq_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, cyclically.
module irq_rr_arbiter #(
  parameter int N_SRC = 8,
  parameter int IDX_W = 3
) (
  input  logic [N_SRC-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx,
  output logic [N_SRC-1:0] grant
);

  logic [IDX_W:0]   pos;
  logic [IDX_W-1:0] j;

  // Scan offsets from farthest to nearest so the nearest hit overwrites.
  always_comb begin
    any = 1'b0;
    idx = '0;
    pos = '0;
    j   = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (pos >= (IDX_W + 1)'(N_SRC)) pos = pos - (IDX_W + 1)'(N_SRC);
      j = pos[IDX_W-1:0];
      if (req[j]) begin
        any = 1'b1;
        idx = j;
      end
    end
  end

  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_grant
    assign grant[gi] = any && (idx == IDX_W'(gi));
  end

endmodule

// File: rtl/irq_source_arbiter.sv
// Latches per-source event pulses and issues them one at a time, round-robin,
// with a programmable idle gap after each completed interrupt.
module irq_source_arbiter
  import irq_pkg::*;
#(
  parameter int         N_SRC       = 8,
  parameter logic [7:0] VECTOR_BASE = 8'h00,
  parameter int         HOLDOFF_W   = 16,
  parameter int         CNT_W       = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [N_SRC-1:0]     src_irq,
  input  logic [N_SRC-1:0]     src_mask,
  input  logic [HOLDOFF_W-1:0] i_holdoff,
  output logic                 int_valid,
  output logic [VEC_W-1:0]     int_vector,
  input  logic                 int_done,
  output logic [N_SRC-1:0]     pending,
  output logic [CNT_W-1:0]     coalesced_cnt,
  output logic                 busy
);

  localparam int IDX_W = idx_width(N_SRC);

  irq_state_e           state_reg, state_next;
  logic [N_SRC-1:0]     pending_reg, pending_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [IDX_W-1:0]     ptr_reg;
  logic [HOLDOFF_W-1:0] hold_reg;
  logic [VEC_W-1:0]     int_vector_reg;

  logic [N_SRC-1:0] eligible, grant, grant_clr, hits;
  logic             any;
  logic [IDX_W-1:0] idx;
  logic             issue;
  logic [5:0]       hit_cnt;

  assign eligible = pending_reg & ~src_mask;

  irq_rr_arbiter #(.N_SRC(N_SRC), .IDX_W(IDX_W)) u_rr (
    .req   (eligible),
    .ptr   (ptr_reg),
    .any   (any),
    .idx   (idx),
    .grant (grant)
  );

  assign issue     = (state_reg == IDLE) && any;
  assign grant_clr = issue ? grant : '0;

  // An event landing on the bit being granted re-arms it rather than coalescing.
  assign hits = src_irq & pending_reg & ~grant_clr;

  always_comb begin
    hit_cnt = '0;
    for (int i = 0; i < N_SRC; i++) hit_cnt = hit_cnt + {5'b0, hits[i]};
  end

  assign pending_next = (pending_reg & ~grant_clr) | src_irq;
  assign cnt_next     = CNT_W'(sat_add(32'(cnt_reg), 32'(hit_cnt),
                                       32'({CNT_W{1'b1}})));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg      <= IDLE;
      pending_reg    <= '0;
      cnt_reg        <= '0;
      ptr_reg        <= '0;
      hold_reg       <= '0;
      int_vector_reg <= '0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      cnt_reg     <= cnt_next;
      if (issue) begin
        int_vector_reg <= VECTOR_BASE + VEC_W'(idx);
        ptr_reg        <= (idx == IDX_W'(N_SRC - 1)) ? '0 : idx + 1'b1;
      end
      if (state_reg == ISSUE && int_done) hold_reg <= i_holdoff;
      else if (state_reg == HOLDOFF && hold_reg != '0) hold_reg <= hold_reg - 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any) state_next = ISSUE;
      ISSUE:   if (int_done) state_next = HOLDOFF;
      HOLDOFF: if (hold_reg == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    int_valid     = (state_reg == ISSUE);
    busy          = (state_reg != IDLE);
    int_vector    = int_vector_reg;
    pending       = pending_reg;
    coalesced_cnt = cnt_reg;
  end

endmodule

// File: tb/tb_irq_source_arbiter.sv
// Directed bench for irq_source_arbiter with hand-computed expectations.
module tb_irq_source_arbiter;
  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [7:0]  src_irq = '0;
  logic [7:0]  src_mask = '0;
  logic [15:0] i_holdoff = '0;
  logic        int_valid;
  logic [7:0]  int_vector;
  logic        int_done = 1'b0;
  logic [7:0]  pending;
  logic [15:0] coalesced_cnt;
  logic        busy;

  int checks = 0;
  int errors = 0;

  irq_source_arbiter #(.N_SRC(8), .VECTOR_BASE(8'h00), .HOLDOFF_W(16), .CNT_W(16)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .src_irq       (src_irq),
    .src_mask      (src_mask),
    .i_holdoff     (i_holdoff),
    .int_valid     (int_valid),
    .int_vector    (int_vector),
    .int_done      (int_done),
    .pending       (pending),
    .coalesced_cnt (coalesced_cnt),
    .busy          (busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1; src_irq = '0; src_mask = '0; int_done = 1'b0;
    tick(); tick();
    i_rst = 1'b0;
  endtask

  // Wait for a request, check it, hold one cycle, then return int_done.
  task automatic serve(input logic [7:0] exp_vec, input string tag);
    int n = 0;
    while (int_valid !== 1'b1 && n < 40) begin tick(); n++; end
    check({tag, "_valid"}, int_valid, 1);
    check({tag, "_vec"}, int_vector, exp_vec);
    tick();
    check({tag, "_stable"}, int_vector, exp_vec);
    int_done = 1'b1;
    tick();
    int_done = 1'b0;
    check({tag, "_drop"}, int_valid, 0);
    $display("irq %s: vector %0d served after %0d wait cycles", tag, int_vector, n);
  endtask

  initial begin
    int n;
    do_reset();
    check("rst_valid", int_valid, 0);
    check("rst_vector", int_vector, 0);
    check("rst_pending", pending, 0);
    check("rst_cnt", coalesced_cnt, 0);
    check("rst_busy", busy, 0);

    // Single source, controller answers 3 cycles after the rise.
    src_irq = 8'h04; tick(); src_irq = '0;
    check("single_pend", pending, 8'h04);
    check("single_notyet", int_valid, 0);
    tick();
    check("single_valid", int_valid, 1);
    check("single_vec", int_vector, 2);
    check("single_clr", pending, 0);
    tick(); tick();
    check("single_held", int_valid, 1);
    int_done = 1'b1; tick(); int_done = 1'b0;
    check("single_drop", int_valid, 0);
    check("single_hold_busy", busy, 1);
    tick();
    check("single_idle", busy, 0);
    $display("irq single: vector 2 done");

    // Round robin over all sources, then wrap back to source 0.
    do_reset();
    src_irq = 8'hFF; tick(); src_irq = '0;
    for (int i = 0; i < 8; i++) serve(8'(i), $sformatf("rr%0d", i));
    check("rr_pend_empty", pending, 0);
    src_irq = 8'h03; tick(); src_irq = '0;
    serve(8'd0, "rr_wrap0");
    serve(8'd1, "rr_wrap1");

    // Coalesce on a masked source, then unmask.
    do_reset();
    src_mask = 8'h20;
    for (int i = 0; i < 4; i++) begin
      src_irq = 8'h20; tick(); src_irq = '0; tick();
    end
    check("coal_cnt", coalesced_cnt, 3);
    check("coal_pend", pending, 8'h20);
    check("coal_masked_idle", busy, 0);
    src_mask = '0;
    serve(8'd5, "coal_unmask");
    for (int i = 0; i < 10; i++) tick();
    check("coal_once", int_valid, 0);
    check("coal_pend_clr", pending, 0);
    check("coal_cnt_keep", coalesced_cnt, 3);

    // Saturation: all masked, all pulsing, 8 hits per cycle after the first.
    src_mask = 8'hFF; src_irq = 8'hFF;
    for (int i = 0; i < 10; i++) tick();
    check("sat_partial", coalesced_cnt, 75);
    for (int i = 0; i < 8200; i++) tick();
    check("sat_cnt", coalesced_cnt, 16'hFFFF);
    check("sat_idle", busy, 0);
    check("sat_pend", pending, 8'hFF);
    src_irq = '0;

    // Holdoff spacing: done edge to next rise is holdoff + 2.
    do_reset();
    i_holdoff = 16'd10;
    src_irq = 8'h06; tick(); src_irq = '0;
    serve(8'd1, "hold_first");
    n = 0;
    while (int_valid !== 1'b1 && n < 40) begin tick(); n++; end
    check("hold_gap", n, 12);
    serve(8'd2, "hold_second");
    i_holdoff = '0;

    // Source 1 re-pulses on the edge it is granted.
    do_reset();
    src_irq = 8'h02; tick();
    tick(); src_irq = '0;
    check("simul_valid", int_valid, 1);
    check("simul_vec", int_vector, 1);
    check("simul_pend", pending, 8'h02);
    check("simul_cnt", coalesced_cnt, 0);
    serve(8'd1, "simul_a");
    serve(8'd1, "simul_b");
    check("simul_cnt_end", coalesced_cnt, 0);

    // Reset while a request is outstanding; late done is ignored.
    do_reset();
    src_irq = 8'h10; tick(); src_irq = '0; tick();
    check("rmid_valid", int_valid, 1);
    check("rmid_vec", int_vector, 4);
    src_irq = 8'h01; i_rst = 1'b1; tick(); i_rst = 1'b0; src_irq = '0;
    check("rmid_drop", int_valid, 0);
    check("rmid_pend", pending, 0);
    check("rmid_busy", busy, 0);
    check("rmid_vec0", int_vector, 0);
    int_done = 1'b1; tick(); int_done = 1'b0;
    check("rmid_late_done", busy, 0);
    src_irq = 8'h30; tick(); src_irq = '0;
    serve(8'd4, "rmid_ptr0");
    serve(8'd5, "rmid_next");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
